// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//   MIPS instruction-fetch stage. Owns the PC, issues reads to a synchronous
//   instruction memory (data one cycle after request) and buffers the returned
//   words in a DEPTH-entry queue. The head entry is presented to ID split into
//   MIPS fields under a valid/ready handshake. A redirect flushes the queue and
//   any in-flight read, then fetch resumes at the new target.
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   imem_req/addr   : read request and word-aligned byte address
//   imem_rdata      : instruction word for the request of the previous cycle
//   redirect/_pc    : flush and restart fetch at redirect_pc (bits [1:0] = 0)
//   id_ready        : ID accepts the head entry this cycle
//   out_valid       : head entry valid
//   out_pc/out_pc4  : head address and head address + 4
//   opcode..jmp_address : head instruction fields (0 while out_valid = 0)
//   count           : occupied queue entries
// ----------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   id_ready,
    output logic                   out_valid,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [ADDR_W-1:0]      out_pc4,
    output logic [5:0]             opcode,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [15:0]            immediate,
    output logic [5:0]             func,
    output logic [25:0]            jmp_address,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fl_pc_q, fl_pc_d;   // address of the in-flight read
    logic              inflight_q, inflight_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
    logic [31:0]       ins_mem_q [DEPTH];

    logic              space;
    logic              issue;
    logic              push;
    logic              pop;
    logic [31:0]       head_ins;
    logic [ADDR_W-1:0] head_pc;

    // Counting the in-flight read as occupied guarantees its response a slot.
    assign space = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);
    assign issue = rst_n & ~redirect & space;
    // A redirect squashes the response arriving this cycle and any pop.
    assign push  = inflight_q & ~redirect;
    assign pop   = out_valid & id_ready & ~redirect;

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    always_comb begin
        pc_d       = pc_q;
        fl_pc_d    = fl_pc_q;
        inflight_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            pc_d     = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + ADDR_W'(4);
                fl_pc_d    = pc_q;
                inflight_d = 1'b1;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            fl_pc_q    <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            fl_pc_q    <= fl_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= fl_pc_q;
            ins_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && push)
            assert (count_q < CW'(DEPTH))
            else $error("if_fetch_queue: push into full queue");
    end
`endif

    assign out_valid = (count_q != '0);
    assign head_ins  = out_valid ? ins_mem_q[rd_ptr_q] : '0;
    assign head_pc   = out_valid ? pc_mem_q[rd_ptr_q]  : '0;

    assign out_pc      = head_pc;
    assign out_pc4     = out_valid ? head_pc + ADDR_W'(4) : '0;
    assign opcode      = head_ins[31:26];
    assign rs          = head_ins[25:21];
    assign rt          = head_ins[20:16];
    assign rd          = head_ins[15:11];
    assign immediate   = head_ins[15:0];
    assign func        = head_ins[5:0];
    assign jmp_address = head_ins[25:0];
    assign count       = count_q;

endmodule
